axi_write_responder: RTL and testbench
======================================

# axi_write_responder

AXI3 write-channel slave endpoint that terminates the AW, W and B channels driven by `AXI_MASTER` in write mode. It accepts one address phase, absorbs the data beats into an internal word-addressed memory, and returns a single write response. It sits beside the read path on the slave side and exposes a combinational debug read port so benches can inspect stored data.

## Interface

- `DATA_WIDTH`, 32, WDATA width; fixed at 32 (4 strobe bits).
- `MEM_DEPTH`, 64, number of 32-bit words; power of two.
- `ACLK` in 1: clock, rising edge.
- `RESETn` in 1: reset, asynchronous, active-low.
- `AWID` in 4: write transaction ID.
- `AWADDR` in 32: byte start address.
- `AWLEN` in 4: beats minus one.
- `AWSIZE` in 3: log2 bytes per beat.
- `AWBURST` in 2: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- `AWVALID` in 1 / `AWREADY` out 1: address handshake.
- `WID` in 4: data beat ID.
- `WDATA` in 32: beat data.
- `WSTRB` in 4: byte enables.
- `WLAST` in 1: final beat marker.
- `WVALID` in 1 / `WREADY` out 1: data handshake.
- `BID` out 4: response ID.
- `BRESP` out 2: 00 OKAY, 10 SLVERR.
- `BVALID` out 1 / `BREADY` in 1: response handshake.
- `dbg_addr` in log2(MEM_DEPTH): debug word index.
- `dbg_rdata` out 32: memory word at `dbg_addr`, combinational.

## Operation

- FSM states: IDLE, DATA, RESP.
- IDLE:
  - `AWREADY`=1.
  - On `AWVALID&&AWREADY`, latch ID, ADDR, LEN, SIZE and BURST; clear the beat counter and error flag; go to DATA.
- DATA:
  - `WREADY`=1.
  - Each `WVALID&&WREADY` beat:
    - If no suppress condition holds, write `WDATA` into the byte lanes enabled by `WSTRB` at word index `addr[log2(MEM_DEPTH)+1:2]`. Upper address bits alias.
    - Increment the beat counter.
    - Advance the address per burst type.
- Address advance:
  - FIXED: address unchanged.
  - INCR: address += 1<<SIZE.
  - WRAP: address += 1<<SIZE, wrapping within the aligned block of (LEN+1)<<SIZE bytes.
- Suppress write and set the error flag when any of these holds:
  - `WID`≠latched ID.
  - SIZE>2.
  - BURST=11.
  - WRAP with LEN not in {1,3,7,15}.
  - Beat counter > LEN.
- Leaving DATA: the beat with `WLAST`=1 moves the FSM to RESP. If the counter ≠ LEN on that beat, set the error flag.
- RESP:
  - `BVALID`=1, `BID`=latched ID, `BRESP`=SLVERR if the error flag is set, else OKAY.
  - On `BREADY`, go to IDLE.
- `AWVALID` is ignored outside IDLE; there is only one outstanding transaction.

## Timing

- Reset values:
  - State IDLE; `AWREADY`=0 during reset, 1 from the first clock after release.
  - `WREADY`=0, `BVALID`=0, `BID`=0, `BRESP`=00.
  - Memory contents are not reset.
- All handshake outputs are registered.
- AW handshake in cycle N: `WREADY` rises in N+1.
- A single-beat burst accepted in N+1 gives `BVALID` in N+2.
- With continuous `WVALID`, one beat is accepted per cycle; throughput is LEN+1 beats in LEN+1 cycles.
- The memory write takes effect at the accepting edge. `dbg_rdata` reflects it in the following cycle.
- `BVALID`, `BID` and `BRESP` are held stable until `BREADY`. `BREADY` already high on the first RESP cycle completes the response in one cycle; the next AW can be accepted one cycle later.
- `RESETn` asserted mid-burst returns to IDLE immediately, drops `WREADY` and `BVALID`, and discards the pending response. Beats already written remain in memory.

## Configuration

- `AXI_WSTRB_EN`:
  - Defined: only byte lanes with `WSTRB` bit=1 are written.
  - Undefined: `WSTRB` is ignored and every accepted, non-suppressed beat writes the full 32-bit word.

## Test plan

- INCR burst: AWID=5, AWADDR=0x1234, AWLEN=0xC, AWSIZE=2, BURST=01; 13 beats with WID=5, data 0x5123+i, WSTRB=F, WLAST on beat 12 -> words 0x0D..0x19 = 0x5123..0x512F; BID=5, BRESP=OKAY, `BVALID` one cycle after the last beat.
- WID mismatch: AWID=5, WID=4, AWLEN=0 -> memory unchanged; BID=5, BRESP=SLVERR.
- Early WLAST: AWLEN=3, WLAST on beat 1 -> 2 words written; BRESP=SLVERR, FSM back in IDLE after `BREADY`.
- WRAP burst: AWADDR=0x38, AWLEN=3, SIZE=2 -> words 0x0E, 0x0F, 0x0C, 0x0D written in order; BRESP=OKAY.
- Strobe and backpressure: WSTRB=0x3, WDATA=0xAAAA5555 over old 0xFFFFFFFF -> 0xFFFF5555 with `AXI_WSTRB_EN` defined, 0xAAAA5555 without. Hold `BREADY`=0 for 5 cycles -> `BVALID`, `BID` and `BRESP` stay stable and `AWREADY` stays 0.
- Reset mid-burst: assert `RESETn`=0 after beat 2 of 4 -> `WREADY`=0 and `BVALID`=0 asynchronously; after release `AWREADY`=1 and a new burst completes OKAY.

Source files
------------

// File: rtl/axi_write_responder_if.sv
// AXI3 write-channel bundle (AW, W and B) shared by a write master and axi_write_responder.
interface axi_write_responder_if;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;

    logic [3:0]  WID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;

    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WID, WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WID, WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/axi_write_responder.sv
// AXI3 write slave: one AW phase, W beats into a word memory, one B response.
// Optional AXI_WSTRB_EN: when defined, only strobed byte lanes are written.
module axi_write_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64
) (
    input  logic                         ACLK,
    input  logic                         RESETn,
    axi_write_responder_if.slave         bus,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]        dbg_rdata
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_e;

    state_e      state_q;
    logic [3:0]  id_q;
    logic [31:0] addr_q;
    logic [3:0]  len_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic [4:0]  cnt_q;
    logic        err_q;
    logic        awready_q;
    logic        wready_q;
    logic        bvalid_q;
    logic [3:0]  bid_q;
    logic [1:0]  bresp_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic             w_fire;
    logic             beat_err;
    logic             last_err;
    logic [31:0]      step;
    logic [31:0]      wrap_mask;
    logic [31:0]      addr_d;
    logic [IDX_W-1:0] wr_idx;

    assign w_fire = bus.WVALID && wready_q;
    assign wr_idx = addr_q[IDX_W+1:2];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        step      = 32'd1 << size_q;
        wrap_mask = (({28'd0, len_q} + 32'd1) << size_q) - 32'd1;
        beat_err  = (bus.WID != id_q) || (size_q > 3'd2) || (burst_q == BURST_RSVD)
                 || ((burst_q == BURST_WRAP) && !(len_q inside {4'd1, 4'd3, 4'd7, 4'd15}))
                 || (cnt_q > {1'b0, len_q});
        last_err  = beat_err || (cnt_q != {1'b0, len_q});
        addr_d    = addr_q;
        case (burst_q)
            BURST_INCR: addr_d = addr_q + step;
            BURST_WRAP: addr_d = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
            default:    addr_d = addr_q;
        endcase
    end

    // NOTE: the memory is deliberately never reset so it maps onto plain RAM; it lives in its own
    // reset-free block and keeps its contents across RESETn.
`ifdef AXI_WSTRB_EN
    always_ff @(posedge ACLK) begin
        if (w_fire && !beat_err) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (bus.WSTRB[b]) mem[wr_idx][8*b +: 8] <= bus.WDATA[8*b +: 8];
            end
        end
    end
`else
    logic unused_strb;
    assign unused_strb = ^bus.WSTRB;

    always_ff @(posedge ACLK) begin
        if (w_fire && !beat_err) mem[wr_idx] <= bus.WDATA;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= S_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (state_q)
                S_IDLE: begin
                    awready_q <= 1'b1;
                    if (bus.AWVALID && awready_q) begin
                        id_q      <= bus.AWID;
                        addr_q    <= bus.AWADDR;
                        len_q     <= bus.AWLEN;
                        size_q    <= bus.AWSIZE;
                        burst_q   <= bus.AWBURST;
                        cnt_q     <= '0;
                        err_q     <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_fire) begin
                        // Saturate at 16: any count above the largest LEN already flags overrun.
                        if (cnt_q != 5'd16) cnt_q <= cnt_q + 5'd1;
                        addr_q <= addr_d;
                        err_q  <= err_q || beat_err;
                        if (bus.WLAST) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= id_q;
                            bresp_q  <= (err_q || last_err) ? RESP_SLVERR : RESP_OKAY;
                            state_q  <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (bus.BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BID     = bid_q;
    assign bus.BRESP   = bresp_q;
    assign dbg_rdata   = mem[dbg_addr];
endmodule

// File: tb/tb_axi_write_responder.sv
// Directed and randomized bench for axi_write_responder against a burst-level memory model.
module tb_axi_write_responder;
    localparam int DEPTH = 64;

    logic        ACLK = 1'b0;
    logic        RESETn;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_rdata;

    axi_write_responder_if bus();

    axi_write_responder #(.DATA_WIDTH(32), .MEM_DEPTH(DEPTH)) dut (
        .ACLK      (ACLK),
        .RESETn    (RESETn),
        .bus       (bus),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    // Reference memory and the transaction currently in flight.
    logic [31:0] ref_mem [DEPTH];
    logic [3:0]  m_id;
    logic [31:0] m_addr;
    int          m_len, m_size, m_burst, m_beat;
    bit          m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout expected DUT handshake", tag);
    endtask

    function automatic bit cfg_bad(input int len, input int size, input int burst);
        return (size > 2) || (burst == 3) ||
               (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    // Byte address of beat i, straight from the burst definitions.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input int size, input int burst, input int i);
        logic [31:0] bytes, blk, base;
        bytes = 32'd1 << size;
        blk   = bytes * 32'(len + 1);
        base  = (start / blk) * blk;
        case (burst)
            0:       return start;
            1:       return start + bytes * 32'(i);
            default: return base + ((start - base + bytes * 32'(i)) % blk);
        endcase
    endfunction

    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr,
                            input int len, input int size, input int burst);
        int n = 0;
        bus.AWID    = id;
        bus.AWADDR  = addr;
        bus.AWLEN   = 4'(len);
        bus.AWSIZE  = 3'(size);
        bus.AWBURST = 2'(burst);
        bus.AWVALID = 1'b1;
        while (bus.AWREADY !== 1'b1 && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        if (n == 50) timeout_fail("aw_handshake");
        @(negedge ACLK);
        bus.AWVALID = 1'b0;
        check("wready_after_aw", {31'd0, bus.WREADY}, 32'd1);
        m_id    = id;
        m_addr  = addr;
        m_len   = len;
        m_size  = size;
        m_burst = burst;
        m_beat  = 0;
        m_err   = cfg_bad(len, size, burst);
    endtask

    task automatic send_beat(input logic [3:0] wid, input logic [31:0] data,
                             input logic [3:0] strb, input bit last);
        logic [31:0] a;
        int          idx;
        check("wready_beat", {31'd0, bus.WREADY}, 32'd1);
        bus.WID    = wid;
        bus.WDATA  = data;
        bus.WSTRB  = strb;
        bus.WLAST  = last;
        bus.WVALID = 1'b1;
        if (wid != m_id || cfg_bad(m_len, m_size, m_burst) || m_beat > m_len) begin
            m_err = 1'b1;
        end else begin
            a   = beat_addr(m_addr, m_len, m_size, m_burst, m_beat);
            idx = int'((a / 4) % DEPTH);
`ifdef AXI_WSTRB_EN
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
            end
`else
            ref_mem[idx] = data;
`endif
        end
        if (last && m_beat != m_len) m_err = 1'b1;
        m_beat++;
        @(negedge ACLK);
        if (last) begin
            bus.WVALID = 1'b0;
            bus.WLAST  = 1'b0;
        end
    endtask

    task automatic resp_phase(input int hold);
        int          n = 0;
        logic [31:0] exp_resp;
        exp_resp = m_err ? 32'd2 : 32'd0;
        check("bvalid_after_last", {31'd0, bus.BVALID}, 32'd1);
        while (bus.BVALID !== 1'b1 && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        if (n == 20) timeout_fail("bvalid_wait");
        check("bid", {28'd0, bus.BID}, {28'd0, m_id});
        check("bresp", {30'd0, bus.BRESP}, exp_resp);
        for (int k = 0; k < hold; k++) begin
            bus.AWVALID = 1'b1;
            @(negedge ACLK);
            check("bvalid_hold", {31'd0, bus.BVALID}, 32'd1);
            check("bid_hold", {28'd0, bus.BID}, {28'd0, m_id});
            check("bresp_hold", {30'd0, bus.BRESP}, exp_resp);
            check("awready_hold", {31'd0, bus.AWREADY}, 32'd0);
        end
        bus.AWVALID = 1'b0;
        bus.BREADY  = 1'b1;
        @(negedge ACLK);
        bus.BREADY = 1'b0;
        check("bvalid_clear", {31'd0, bus.BVALID}, 32'd0);
        check("awready_back", {31'd0, bus.AWREADY}, 32'd1);
    endtask

    task automatic read_word(input int w, output logic [31:0] v);
        @(negedge ACLK);
        dbg_addr = 6'(w);
        #1;
        v = dbg_rdata;
    endtask

    task automatic check_mem(input string tag);
        logic [31:0] v;
        for (int w = 0; w < DEPTH; w++) begin
            read_word(w, v);
            check($sformatf("%s[%0d]", tag, w), v, ref_mem[w]);
        end
    endtask

    task automatic check_word(input string tag, input int w, input logic [31:0] exp);
        logic [31:0] v;
        read_word(w, v);
        check(tag, v, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lens[4] = '{1, 3, 7, 15};
        int len, size, burst, nbeats, r;
        logic [3:0]  id, wid;
        logic [31:0] addr;

        RESETn      = 1'b0;
        bus.AWID    = '0;
        bus.AWADDR  = '0;
        bus.AWLEN   = '0;
        bus.AWSIZE  = '0;
        bus.AWBURST = '0;
        bus.AWVALID = 1'b0;
        bus.WID     = '0;
        bus.WDATA   = '0;
        bus.WSTRB   = '0;
        bus.WLAST   = 1'b0;
        bus.WVALID  = 1'b0;
        bus.BREADY  = 1'b0;
        dbg_addr    = '0;

        // Reset values
        repeat (2) @(negedge ACLK);
        check("rst_awready", {31'd0, bus.AWREADY}, 32'd0);
        check("rst_wready", {31'd0, bus.WREADY}, 32'd0);
        check("rst_bvalid", {31'd0, bus.BVALID}, 32'd0);
        check("rst_bid", {28'd0, bus.BID}, 32'd0);
        check("rst_bresp", {30'd0, bus.BRESP}, 32'd0);
        RESETn = 1'b1;
        @(negedge ACLK);
        check("awready_after_rst", {31'd0, bus.AWREADY}, 32'd1);

        // Fill every word so the model knows the whole memory
        for (int blk = 0; blk < 4; blk++) begin
            aw_phase(4'd1, 32'(blk * 64), 15, 2, 1);
            for (int i = 0; i < 16; i++) send_beat(4'd1, $urandom, 4'hF, i == 15);
            resp_phase(0);
        end
        check_mem("preload");

        // INCR burst of 13 beats
        aw_phase(4'd5, 32'h1234, 12, 2, 1);
        for (int i = 0; i < 13; i++) send_beat(4'd5, 32'h5123 + 32'(i), 4'hF, i == 12);
        resp_phase(0);
        check_word("incr_first", 'h0D, 32'h5123);
        check_word("incr_last", 'h19, 32'h512F);
        check_mem("incr");

        // WID mismatch
        aw_phase(4'd5, 32'h40, 0, 2, 1);
        send_beat(4'd4, 32'hDEADBEEF, 4'hF, 1'b1);
        resp_phase(0);
        check_mem("wid_mismatch");

        // Early WLAST
        aw_phase(4'd3, 32'h80, 3, 2, 1);
        send_beat(4'd3, $urandom, 4'hF, 1'b0);
        send_beat(4'd3, $urandom, 4'hF, 1'b1);
        resp_phase(0);
        check_mem("early_wlast");

        // WRAP burst
        aw_phase(4'd7, 32'h38, 3, 2, 2);
        for (int i = 0; i < 4; i++) send_beat(4'd7, 32'hA0 + 32'(i), 4'hF, i == 3);
        resp_phase(0);
        check_word("wrap_0E", 'h0E, 32'hA0);
        check_word("wrap_0F", 'h0F, 32'hA1);
        check_word("wrap_0C", 'h0C, 32'hA2);
        check_word("wrap_0D", 'h0D, 32'hA3);
        check_mem("wrap");

        // Strobe and backpressure; 0x100 aliases word 0
        aw_phase(4'd2, 32'h100, 0, 2, 1);
        send_beat(4'd2, 32'hFFFFFFFF, 4'hF, 1'b1);
        resp_phase(0);
        aw_phase(4'd2, 32'h100, 0, 2, 1);
        send_beat(4'd2, 32'hAAAA5555, 4'h3, 1'b1);
        resp_phase(5);
`ifdef AXI_WSTRB_EN
        check_word("strobe", 0, 32'hFFFF5555);
`else
        check_word("strobe", 0, 32'hAAAA5555);
`endif
        check_mem("strobe");

        // Reset mid-burst after beat 2 of 4
        aw_phase(4'd9, 32'h20, 3, 2, 1);
        send_beat(4'd9, $urandom, 4'hF, 1'b0);
        send_beat(4'd9, $urandom, 4'hF, 1'b0);
        bus.WVALID = 1'b0;
        #2;
        RESETn = 1'b0;
        #1;
        check("midrst_wready", {31'd0, bus.WREADY}, 32'd0);
        check("midrst_bvalid", {31'd0, bus.BVALID}, 32'd0);
        check("midrst_awready", {31'd0, bus.AWREADY}, 32'd0);
        @(negedge ACLK);
        RESETn = 1'b1;
        @(negedge ACLK);
        check("awready_after_midrst", {31'd0, bus.AWREADY}, 32'd1);
        check_mem("midrst");
        aw_phase(4'd9, 32'h20, 3, 2, 1);
        for (int i = 0; i < 4; i++) send_beat(4'd9, $urandom, 4'hF, i == 3);
        resp_phase(0);
        check_mem("post_rst");

        // Randomized bursts
        for (int t = 0; t < 24; t++) begin
            id   = 4'($urandom_range(0, 15));
            len  = $urandom_range(0, 15);
            size = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
            r    = $urandom_range(0, 7);
            burst = (r == 0) ? 3 : (r < 3) ? 0 : (r < 5) ? 1 : 2;
            if (burst == 2 && $urandom_range(0, 3) != 0) len = lens[$urandom_range(0, 3)];
            addr   = $urandom & ~((32'd1 << size) - 32'd1);
            wid    = ($urandom_range(0, 5) == 0) ? (id ^ 4'd1) : id;
            nbeats = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 16) : len + 1;
            aw_phase(id, addr, len, size, burst);
            for (int i = 0; i < nbeats; i++) begin
                send_beat(wid, $urandom, 4'($urandom_range(0, 15)), i == nbeats - 1);
            end
            resp_phase($urandom_range(0, 3));
            check_mem($sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
